// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, line/frame total derivation and sync polarity encoding.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VIEW  = 640;
  localparam int unsigned DEF_H_FRONT = 16;
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BACK  = 48;
  localparam int unsigned DEF_V_VIEW  = 480;
  localparam int unsigned DEF_V_FRONT = 10;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BACK  = 33;

  localparam int unsigned MAX_TOTAL      = 1024;
  localparam int unsigned MAX_SYNC_DELAY = 7;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  function automatic int unsigned h_total(input int unsigned view, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return view + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned view, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return view + front + sync + back;
  endfunction

  // Pin level for a sync signal given its polarity and whether it is asserted.
  function automatic logic sync_level(input sync_pol_e pol, input logic act);
    return (pol == SYNC_ACTIVE_HIGH) ? act : ~act;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register with a per-bit reset value; DEPTH 0 is a straight wire.
module sync_delay_line #(
  parameter int unsigned    DEPTH   = 3,
  parameter int unsigned    WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, i_clk, i_rst, i_en};
      assign o_data   = i_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else if (i_en) begin
          r_stage[0] <= i_data;
          for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Raster counter with registered sync/active decodes, line/frame strobes, frame counter
// and a px_en-gated delayed copy of the sync/active bundle for lagging colour pipelines.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIEW      = DEF_H_VIEW,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VIEW      = DEF_V_VIEW,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter bit          H_SYNC_POL  = 1'b0,
  parameter bit          V_SYNC_POL  = 1'b0,
  parameter int unsigned SYNC_DELAY  = 3,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   px_en,
  output logic [9:0]             x_px,
  output logic [9:0]             y_px,
  output logic                   activevideo,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hsync_d,
  output logic                   vsync_d,
  output logic                   active_d,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL = h_total(H_VIEW, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_VIEW, V_FRONT, V_SYNC, V_BACK);

  generate
    if (H_VIEW == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_VIEW == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 || FRAME_CNT_W == 0) begin : g_bad_zero
      $error("vga_sync_gen: timing parameters and FRAME_CNT_W must be non-zero");
    end
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_delay
      $error("vga_sync_gen: SYNC_DELAY must be 0..7");
    end
  endgenerate

  localparam sync_pol_e  H_POL     = sync_pol_e'(H_SYNC_POL);
  localparam sync_pol_e  V_POL     = sync_pol_e'(V_SYNC_POL);
  localparam logic [9:0] X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIEW    = 10'(H_VIEW);
  localparam logic [9:0] Y_VIEW    = 10'(V_VIEW);
  localparam logic [9:0] HS_START  = 10'(H_VIEW + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VIEW + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VIEW + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VIEW + V_FRONT + V_SYNC);
  localparam logic [2:0] DLY_RST   = {sync_level(H_POL, 1'b0), sync_level(V_POL, 1'b0), 1'b0};

  logic [9:0]             r_x, r_y;
  logic                   r_active, r_hsync, r_vsync;
  logic                   r_line_start, r_frame_start;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic [9:0] w_x_nxt, w_y_nxt;
  logic       w_x_wrap, w_y_wrap;
  logic       w_active_nxt, w_hsync_nxt, w_vsync_nxt;
  logic [2:0] w_delayed;

  // Decodes look at the next-state counters so they land in the same cycle as x/y.
  always_comb begin
    w_x_wrap     = (r_x == X_LAST);
    w_y_wrap     = (r_y == Y_LAST);
    w_x_nxt      = w_x_wrap ? '0 : r_x + 10'd1;
    w_y_nxt      = r_y;
    if (w_x_wrap) w_y_nxt = w_y_wrap ? '0 : r_y + 10'd1;
    w_active_nxt = (w_x_nxt < X_VIEW) && (w_y_nxt < Y_VIEW);
    w_hsync_nxt  = sync_level(H_POL, (w_x_nxt >= HS_START) && (w_x_nxt < HS_END));
    w_vsync_nxt  = sync_level(V_POL, (w_y_nxt >= VS_START) && (w_y_nxt < VS_END));
  end

  // Strobes use the wrap flags: next x is 0 exactly when the current x is the last column.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x           <= X_LAST;
      r_y           <= Y_LAST;
      r_active      <= 1'b0;
      r_hsync       <= sync_level(H_POL, 1'b0);
      r_vsync       <= sync_level(V_POL, 1'b0);
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else if (px_en) begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_active      <= w_active_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_line_start  <= w_x_wrap;
      r_frame_start <= w_x_wrap && w_y_wrap;
      if (w_x_wrap && w_y_wrap) r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  sync_delay_line #(
    .DEPTH   (SYNC_DELAY),
    .WIDTH   (3),
    .RST_VAL (DLY_RST)
  ) u_sync_delay (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_en   (px_en),
    .i_data ({r_hsync, r_vsync, r_active}),
    .o_data (w_delayed)
  );

  assign x_px        = r_x;
  assign y_px        = r_y;
  assign activevideo = r_active;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign {hsync_d, vsync_d, active_d} = w_delayed;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage for the VGA renderers, including the clock display.
- Generates the raster position (x_px, y_px), activevideo, and raw hsync/vsync from a single pixel clock.
- Also provides hsync/vsync/active copies delayed by a fixed pipeline depth, so sync edges line up with renderer colour output that lags by several clocks.
- Also provides line/frame strobes and a frame counter for animation and button sampling.

Parameters:
- H_VIEW, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (px)
- H_SYNC, 96, hsync width (px)
- H_BACK, 48, horizontal back porch (px)
- V_VIEW, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, 1 = hsync active-high, 0 = active-low
- V_SYNC_POL, 0, 1 = vsync active-high, 0 = active-low
- SYNC_DELAY, 3, depth in px_en ticks of the delayed outputs; 0 to 7 legal
- FRAME_CNT_W, 8, frame counter width

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high reset
- px_en  in  1  pixel advance enable; tie high for 25 MHz operation
- x_px  out  10  current column, 0..H_TOTAL-1
- y_px  out  10  current line, 0..V_TOTAL-1
- activevideo  out  1  high when x_px<H_VIEW and y_px<V_VIEW
- hsync  out  1  raw hsync, aligned with x_px
- vsync  out  1  raw vsync, aligned with y_px
- hsync_d  out  1  hsync delayed by SYNC_DELAY ticks
- vsync_d  out  1  vsync delayed by SYNC_DELAY ticks
- active_d  out  1  activevideo delayed by SYNC_DELAY ticks
- line_start  out  1  one-clk pulse on entry to x_px==0
- frame_start  out  1  one-clk pulse on entry to (0,0)
- frame_count  out  FRAME_CNT_W  frames started since reset, wraps

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Elaboration must fail if any timing parameter is 0, if H_TOTAL or V_TOTAL exceeds 1024, or if SYNC_DELAY exceeds 7.
- All outputs are registered. Nothing is combinational from inputs.
- Reset values:
  - x_px = H_TOTAL-1, y_px = V_TOTAL-1 (last pixel of a frame).
  - activevideo = 0; hsync and vsync at their inactive level.
  - All delay stages hold inactive values (sync at inactive level, active = 0), so hsync_d, vsync_d and active_d are inactive too.
  - line_start = 0, frame_start = 0, frame_count = 0.
- Advance: on each clk with px_en=1 and reset=0, x_px increments.
  - x_px == H_TOTAL-1 → x_px = 0 and y_px increments.
  - y_px == V_TOTAL-1 at the same time → y_px = 0.
- px_en = 0: every register holds, including the delay pipeline. line_start and frame_start are 0 on such clocks.
- Decodes are computed from next-state counters, so they are valid in the same cycle as the new x_px/y_px (zero relative latency):
  - activevideo is per its port definition.
  - hsync is active for H_VIEW+H_FRONT ≤ x_px < H_VIEW+H_FRONT+H_SYNC (656..751).
  - vsync is active for V_VIEW+V_FRONT ≤ y_px < V_VIEW+V_FRONT+V_SYNC (490..491).
  - Active level follows the *_POL parameters.
- line_start = 1 for exactly the clk in which x_px first becomes 0. frame_start = 1 only when y_px also becomes 0.
- frame_count increments by 1 coincident with frame_start, wrapping modulo 2^FRAME_CNT_W. The first frame after reset shows frame_count = 1.
- Delay line: a SYNC_DELAY-stage shift register that advances only when px_en=1.
  - SYNC_DELAY = 0: the *_d outputs equal the raw outputs.
- Reset asserted mid-frame: all outputs return to their reset values on the next clk. No partial strobes are emitted.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default timing constants;
  - H_TOTAL/V_TOTAL derivation functions;
  - the sync polarity encodings.
- One sub-module, sync_delay_line: parameterised depth and width, with enable and a per-bit reset value. It is instantiated once for the {hsync, vsync, activevideo} bundle.

Test Plan:
- Reset, then deassert with px_en=1 → first clk x=0, y=0, activevideo=1, line_start=1, frame_start=1, frame_count=1; next clk both strobes are 0.
- Run one line → activevideo falls at x=640; hsync goes 0 at x=656 and returns to 1 at x=752; at x=799→0 y increments and line_start pulses.
- Run a full frame → vsync = 0 for y=490..491 only; at (799,524)→(0,0) frame_start=1 and frame_count=2; total of 420000 clks between frame_start pulses.
- Toggle px_en pattern 1,0,0,1 → counters and delay line hold on the 0 cycles; no strobe repeats while held at x=0.
- SYNC_DELAY=3 → hsync_d falls exactly 3 px_en ticks after hsync; with SYNC_DELAY=0, hsync_d equals hsync every cycle.
- Assert reset at (300,200) for 1 clk → x=799, y=524, syncs inactive, *_d inactive, frame_count=0; the next frame starts cleanly at (0,0).
